wr_pntrs_and_full: RTL and testbench
====================================

// Module: wr_pntrs_and_full
// PURPOSE
//  Write-domain pointer and full-flag logic of the dual-clock FIFO; upstream partner of the read-side pointer/empty stage.
//  Holds the binary write pointer, gives the RAM its write address and exports the Gray write pointer to the read domain.
//  Synchronises the Gray read pointer into wr_clk_i. Produces full, almost-full and the write-side fill level.
// PARAMETERS
//  AWIDTH           3   RAM address width; FIFO depth = 2**AWIDTH; legal range >= 2
//  ALMOST_FULL_LVL  6   wr_almost_full_o threshold in words; legal range 1..2**AWIDTH
//  SYNC_STAGES      2   flop stages for the read-pointer synchroniser; legal range >= 2
// PORTS
//  wr_clk_i           in   1         write clock; the only clock in this block
//  aclr_i             in   1         reset, asynchronous, active-high
//  wr_req_i           in   1         write request; accepted only when wr_full_o==0
//  rd_pntr_gray_i     in   AWIDTH+1  Gray read pointer, launched from rd_clk domain, unsynchronised
//  wr_pntr_o          out  AWIDTH    RAM write address (binary pointer LSBs)
//  wr_pntr_gray_rd_o  out  AWIDTH+1  registered Gray write pointer, sent to the read domain
//  wr_full_o          out  1         FIFO full, registered
//  wr_almost_full_o   out  1         wr_usedw_o >= ALMOST_FULL_LVL
//  wr_usedw_o         out  AWIDTH+1  words used as seen from the write side, range 0..2**AWIDTH
// BEHAVIOUR
//  - Reset (async, on aclr_i rise): binary pointer, wr_pntr_gray_rd_o and every sync flop go to 0.
//    wr_full_o=0, wr_almost_full_o=0, wr_usedw_o=0. The reset may arrive mid-operation; all state clears at once.
//  - wr_pntr_bin is AWIDTH+1 bits. wr_pntr_bin_next = (wr_req_i & ~wr_full_o) ? wr_pntr_bin+1 : wr_pntr_bin.
//    It wraps modulo 2**(AWIDTH+1). The MSB is the lap bit.
//  - wr_pntr_gray_next = bin2gray(wr_pntr_bin_next). wr_pntr_bin and wr_pntr_gray_rd_o load on the same edge.
//    Gray output is registered only, never combinational, so that it is CDC-safe.
//  - Accepted write: wr_pntr_o shows the address being written in that cycle and increments on that cycle's edge.
//  - Synchroniser: rd_pntr_gray_i passes through a SYNC_STAGES flop chain to give rd_gray_s. Nothing else samples it.
//    rd_bin_s = gray2bin(rd_gray_s).
//  - Full: full_next = (wr_pntr_gray_next == {~rd_gray_s[AWIDTH:AWIDTH-1], rd_gray_s[AWIDTH-2:0]}).
//    wr_full_o is registered from full_next, so it asserts on the edge that accepts the filling write.
//  - A write request while wr_full_o=1 is ignored: no pointer change and no error flag. Overflow protection is internal.
//  - A read-side pop reaches wr_full_o after SYNC_STAGES+1 wr_clk edges at most. Full is pessimistic and never optimistic.
//  - wr_usedw_o = wr_pntr_bin - rd_bin_s, computed in AWIDTH+1 bits, modulo arithmetic.
//    Full depth reads 2**AWIDTH and does not wrap to 0.
//    Computed combinationally from registers only: wr_pntr_bin and the sync-chain output.
//  - wr_almost_full_o = (wr_usedw_o >= ALMOST_FULL_LVL). Combinational from the same registers; no glitch-sensitive consumers.
//  - Write and read pointer change in the same wr_clk cycle: the write is judged only against the old wr_full_o.
//    The read becomes visible later through the sync chain.
// STRUCTURE
//  - Shared package fifo_pkg holds bin2gray/gray2bin functions, plus the DEPTH = 2**AWIDTH constant helper.
//  - Sub-module gray_sync: a SYNC_STAGES x (AWIDTH+1) flop chain clocked by wr_clk_i, cleared by aclr_i.
//    The read side reuses the same gray_sync for the write pointer.
//  - Binary/Gray conversion is done with the existing bg_transf instance, for parity with the read side.
// TESTING (AWIDTH=3, ALMOST_FULL_LVL=6, SYNC_STAGES=2)
//  1. Reset: pulse aclr_i mid-clock with no clock edge.
//     -> all outputs 0 immediately; wr_full_o=0, wr_usedw_o=0.
//  2. Fill: rd_pntr_gray_i=0, then 8 consecutive writes.
//     -> wr_pntr_o 0..7 then 0; wr_full_o=1 on the 8th write edge; wr_pntr_gray_rd_o=4'b1100; wr_usedw_o=8.
//     A 9th request leaves everything unchanged.
//  3. Drain: while full, set rd_pntr_gray_i=4'b0001.
//     -> wr_full_o falls 3 edges later; wr_usedw_o=7; the next write re-asserts full.
//  4. Almost-full: from empty, do 5 writes then a 6th write.
//     -> wr_almost_full_o=0 after 5, =1 after the 6th; =0 again once rd_gray_s shows 1 word read.
//  5. Wrap: 20 writes with a model read pointer stepping in Gray, 2 words behind.
//     -> the lap bit toggles at writes 8 and 16; wr_usedw_o always matches the model; wr_full_o never asserts.
//  6. Mid-run reset: with wr_usedw_o=5, assert aclr_i together with wr_req_i=1.
//     -> pointers 0 and no write accepted; after release, the first write uses address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer stages: Gray/binary conversion
// and the depth constant derived from the address width.
package fifo_pkg;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray codes convert correctly because the upper bits stay 0.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/bg_transf.sv
// Combinational binary-to-Gray and Gray-to-binary converter pair, shared in
// form with the read-side pointer stage.
module bg_transf
  import fifo_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] bin_val,
  output logic [W-1:0] gray_of_bin,
  input  logic [W-1:0] gray_val,
  output logic [W-1:0] bin_of_gray
);

  assign gray_of_bin = W'(bin2gray(32'(bin_val)));
  assign bin_of_gray = W'(gray2bin(32'(gray_val)));

endmodule

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock
// domain; every stage clears asynchronously.
module gray_sync #(
  parameter int unsigned W      = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        chain[i] <= '0;
      end
    end else begin
      chain[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/wr_pntrs_and_full.sv
// Write-domain half of the dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchroniser, registered full flag, almost-full and fill level.
module wr_pntrs_and_full
  import fifo_pkg::*;
#(
  parameter int unsigned AWIDTH          = 3,
  parameter int unsigned ALMOST_FULL_LVL = 6,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic              wr_clk_i,
  input  logic              aclr_i,
  input  logic              wr_req_i,
  input  logic [AWIDTH:0]   rd_pntr_gray_i,
  output logic [AWIDTH-1:0] wr_pntr_o,
  output logic [AWIDTH:0]   wr_pntr_gray_rd_o,
  output logic              wr_full_o,
  output logic              wr_almost_full_o,
  output logic [AWIDTH:0]   wr_usedw_o
);

  localparam int unsigned DEPTH = depth(AWIDTH);
  localparam logic [AWIDTH:0] AF_LVL =
    (AWIDTH+1)'((ALMOST_FULL_LVL > DEPTH) ? DEPTH : ALMOST_FULL_LVL);

  logic [AWIDTH:0] wr_pntr_bin;
  logic [AWIDTH:0] wr_pntr_bin_next;
  logic [AWIDTH:0] wr_pntr_gray_next;
  logic [AWIDTH:0] rd_gray_s;
  logic [AWIDTH:0] rd_bin_s;
  logic [AWIDTH:0] full_match;
  logic            full_next;

  gray_sync #(
    .W      (AWIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (wr_clk_i),
    .rst (aclr_i),
    .d   (rd_pntr_gray_i),
    .q   (rd_gray_s)
  );

  bg_transf #(
    .W (AWIDTH + 1)
  ) u_bg (
    .bin_val     (wr_pntr_bin_next),
    .gray_of_bin (wr_pntr_gray_next),
    .gray_val    (rd_gray_s),
    .bin_of_gray (rd_bin_s)
  );

  // Writes are judged only against the registered full flag, so a write is
  // never accepted into a full FIFO even if a read is in flight.
  assign wr_pntr_bin_next = wr_pntr_bin + (AWIDTH+1)'(wr_req_i & ~wr_full_o);

  // A full FIFO's write pointer equals the read pointer one lap ahead, which
  // in Gray code flips the two top bits.
  assign full_match = {~rd_gray_s[AWIDTH:AWIDTH-1], rd_gray_s[AWIDTH-2:0]};
  assign full_next  = (wr_pntr_gray_next == full_match);

  always_ff @(posedge wr_clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      wr_pntr_bin       <= '0;
      wr_pntr_gray_rd_o <= '0;
      wr_full_o         <= 1'b0;
    end else begin
      wr_pntr_bin       <= wr_pntr_bin_next;
      wr_pntr_gray_rd_o <= wr_pntr_gray_next;
      wr_full_o         <= full_next;
    end
  end

  assign wr_pntr_o        = wr_pntr_bin[AWIDTH-1:0];
  assign wr_usedw_o       = wr_pntr_bin - rd_bin_s;
  assign wr_almost_full_o = (wr_usedw_o >= AF_LVL);

endmodule

// File: tb/tb_wr_pntrs_and_full.sv
// Self-checking bench for wr_pntrs_and_full: directed scenarios plus random
// traffic, compared against a word-count model of the write side.
module tb_wr_pntrs_and_full;

  logic       wr_clk_i = 1'b0;
  logic       aclr_i   = 1'b1;
  logic       wr_req_i = 1'b0;
  logic [3:0] rd_pntr_gray_i = '0;
  logic [2:0] wr_pntr_o;
  logic [3:0] wr_pntr_gray_rd_o;
  logic       wr_full_o;
  logic       wr_almost_full_o;
  logic [3:0] wr_usedw_o;

  int errors = 0;
  int checks = 0;

  // Model: counts of words written, read (driven), and read as seen after sync.
  int  m_w, m_rd, m_s1, m_s2;
  bit  m_full;

  wr_pntrs_and_full #(
    .AWIDTH          (3),
    .ALMOST_FULL_LVL (6),
    .SYNC_STAGES     (2)
  ) dut (
    .wr_clk_i          (wr_clk_i),
    .aclr_i            (aclr_i),
    .wr_req_i          (wr_req_i),
    .rd_pntr_gray_i    (rd_pntr_gray_i),
    .wr_pntr_o         (wr_pntr_o),
    .wr_pntr_gray_rd_o (wr_pntr_gray_rd_o),
    .wr_full_o         (wr_full_o),
    .wr_almost_full_o  (wr_almost_full_o),
    .wr_usedw_o        (wr_usedw_o)
  );

  always #5 wr_clk_i = ~wr_clk_i;

  function automatic logic [3:0] to_gray(input int n);
    logic [3:0] b;
    b = 4'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] exp_usedw();
    return 4'((m_w - m_s2) & 15);
  endfunction

  task automatic set_rd(input int n);
    m_rd = n;
    rd_pntr_gray_i = to_gray(n);
  endtask

  // One write-clock cycle; the model advances with the same edge.
  task automatic tick(input bit req);
    int w_new;
    wr_req_i = req;
    @(posedge wr_clk_i);
    w_new  = m_w + ((req && !m_full) ? 1 : 0);
    m_full = (((w_new - m_s2) & 15) == 8);
    m_s2   = m_s1;
    m_s1   = m_rd;
    m_w    = w_new;
    #1;
  endtask

  task automatic do_reset();
    wr_req_i = 1'b0;
    set_rd(0);
    #1 aclr_i = 1'b1;
    #1 aclr_i = 1'b0;
    m_w = 0; m_s1 = 0; m_s2 = 0; m_full = 0;
  endtask

  task automatic test_reset();
    tick(1);
    tick(1);
    tick(1);
    #1 aclr_i = 1'b1;
    #1;
    checks++;
    if ({wr_pntr_o, wr_pntr_gray_rd_o, wr_full_o, wr_almost_full_o, wr_usedw_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_async outputs got=%h exp=0",
               {wr_pntr_o, wr_pntr_gray_rd_o, wr_full_o, wr_almost_full_o, wr_usedw_o});
    end
    aclr_i = 1'b0;
    m_w = 0; m_s1 = 0; m_s2 = 0; m_full = 0;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_pntr_o !== 3'(i)) begin
        errors++;
        $display("[TB] FAIL fill_addr[%0d] got=%0d exp=%0d", i, wr_pntr_o, i);
      end
      tick(1);
    end
    checks++;
    if (wr_full_o !== 1'b1 || wr_pntr_gray_rd_o !== 4'b1100 || wr_usedw_o !== 4'd8 || wr_pntr_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL fill_end full=%b gray=%b usedw=%0d addr=%0d exp full=1 gray=1100 usedw=8 addr=0",
               wr_full_o, wr_pntr_gray_rd_o, wr_usedw_o, wr_pntr_o);
    end
    tick(1);
    checks++;
    if (wr_full_o !== 1'b1 || wr_pntr_gray_rd_o !== 4'b1100 || wr_usedw_o !== 4'd8 || wr_pntr_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL fill_overflow full=%b gray=%b usedw=%0d addr=%0d exp unchanged",
               wr_full_o, wr_pntr_gray_rd_o, wr_usedw_o, wr_pntr_o);
    end
  endtask

  task automatic test_drain();
    logic exp_full [3] = '{1'b1, 1'b1, 1'b0};
    set_rd(1);
    for (int i = 0; i < 3; i++) begin
      tick(0);
      checks++;
      if (wr_full_o !== exp_full[i] || wr_full_o !== m_full) begin
        errors++;
        $display("[TB] FAIL drain_full[%0d] got=%b exp=%b", i, wr_full_o, exp_full[i]);
      end
    end
    checks++;
    if (wr_usedw_o !== 4'd7) begin
      errors++;
      $display("[TB] FAIL drain_usedw got=%0d exp=7", wr_usedw_o);
    end
    tick(1);
    checks++;
    if (wr_full_o !== 1'b1 || wr_usedw_o !== 4'd8) begin
      errors++;
      $display("[TB] FAIL drain_refill full=%b usedw=%0d exp full=1 usedw=8", wr_full_o, wr_usedw_o);
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1);
    checks++;
    if (wr_almost_full_o !== 1'b0 || wr_usedw_o !== 4'd5) begin
      errors++;
      $display("[TB] FAIL af_at5 af=%b usedw=%0d exp af=0 usedw=5", wr_almost_full_o, wr_usedw_o);
    end
    tick(1);
    checks++;
    if (wr_almost_full_o !== 1'b1 || wr_usedw_o !== 4'd6) begin
      errors++;
      $display("[TB] FAIL af_at6 af=%b usedw=%0d exp af=1 usedw=6", wr_almost_full_o, wr_usedw_o);
    end
    set_rd(1);
    tick(0);
    checks++;
    if (wr_almost_full_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL af_sync_hold got=%b exp=1", wr_almost_full_o);
    end
    tick(0);
    checks++;
    if (wr_almost_full_o !== 1'b0 || wr_usedw_o !== 4'd5) begin
      errors++;
      $display("[TB] FAIL af_after_read af=%b usedw=%0d exp af=0 usedw=5", wr_almost_full_o, wr_usedw_o);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      set_rd((m_w > 2) ? m_w - 2 : 0);
      checks++;
      if (wr_pntr_gray_rd_o[3] !== 1'(((i >> 3) & 1)) || wr_usedw_o !== exp_usedw()
          || wr_full_o !== 1'b0 || wr_pntr_gray_rd_o !== to_gray(m_w)) begin
        errors++;
        $display("[TB] FAIL wrap[%0d] lap=%b usedw=%0d full=%b gray=%b exp lap=%0d usedw=%0d full=0 gray=%b",
                 i, wr_pntr_gray_rd_o[3], wr_usedw_o, wr_full_o, wr_pntr_gray_rd_o,
                 (i >> 3) & 1, exp_usedw(), to_gray(m_w));
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      tick(($urandom % 4) != 0);
      if (m_rd < m_w && ($urandom % 3) == 0) set_rd(m_rd + 1);
      checks++;
      if (wr_usedw_o !== exp_usedw() || wr_full_o !== m_full
          || wr_almost_full_o !== (exp_usedw() >= 4'd6)
          || wr_pntr_o !== 3'(m_w & 7) || wr_pntr_gray_rd_o !== to_gray(m_w)) begin
        errors++;
        $display("[TB] FAIL random[%0d] usedw=%0d full=%b af=%b addr=%0d gray=%b exp usedw=%0d full=%b af=%b addr=%0d gray=%b",
                 i, wr_usedw_o, wr_full_o, wr_almost_full_o, wr_pntr_o, wr_pntr_gray_rd_o,
                 exp_usedw(), m_full, exp_usedw() >= 4'd6, m_w & 7, to_gray(m_w));
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) tick(1);
    checks++;
    if (wr_usedw_o !== 4'd5) begin
      errors++;
      $display("[TB] FAIL midrst_pre usedw got=%0d exp=5", wr_usedw_o);
    end
    aclr_i   = 1'b1;
    wr_req_i = 1'b1;
    @(posedge wr_clk_i);
    #1;
    checks++;
    if (wr_pntr_o !== 3'd0 || wr_pntr_gray_rd_o !== 4'd0 || wr_usedw_o !== 4'd0 || wr_full_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_held addr=%0d gray=%b usedw=%0d full=%b exp all 0",
               wr_pntr_o, wr_pntr_gray_rd_o, wr_usedw_o, wr_full_o);
    end
    aclr_i = 1'b0;
    m_w = 0; m_s1 = 0; m_s2 = 0; m_full = 0;
    checks++;
    if (wr_pntr_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL midrst_first_addr got=%0d exp=0", wr_pntr_o);
    end
    tick(1);
    checks++;
    if (wr_pntr_o !== 3'd1 || wr_usedw_o !== 4'd1) begin
      errors++;
      $display("[TB] FAIL midrst_after addr=%0d usedw=%0d exp addr=1 usedw=1", wr_pntr_o, wr_usedw_o);
    end
  endtask

  initial begin
    m_w = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_full = 0;
    repeat (2) @(posedge wr_clk_i);
    #1 aclr_i = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_almost_full();
    test_wrap();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
